// File: rtl/micro_tlb_pkg.sv
// micro_tlb_pkg: entry layouts, exception codes and segment bases shared by the micro TLB
package micro_tlb_pkg;
  localparam logic [31:0] KSEG0_BASE = 32'h8000_0000;
  localparam logic [31:0] KSEG1_BASE = 32'hA000_0000;
  typedef enum logic [1:0] {
    EXC_NONE     = 2'd0,
    EXC_REFILL   = 2'd1,
    EXC_INVALID  = 2'd2,
    EXC_MODIFIED = 2'd3
  } exc_e;
  typedef struct packed {
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } TLB_Entry;
  typedef struct packed {
    logic        valid;
    logic        found;
    logic [18:0] vpn2;
    TLB_Entry    e;
  } utlb_entry_t;
  function automatic logic is_cached(logic [2:0] c);
    return c == 3'd3;
  endfunction
endpackage

// File: rtl/micro_tlb_victim.sv
// micro_tlb_victim: picks the lowest invalid entry, else the round-robin pointer
module micro_tlb_victim #(
  parameter int ENTRIES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ENTRIES-1:0]         valid,
  input  logic                       fill,
  output logic [$clog2(ENTRIES)-1:0] victim
);
  localparam int IW = $clog2(ENTRIES);
  logic [IW-1:0] rr, first;
  always_comb begin
    first = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (!valid[i]) first = IW'(i);
  end
  assign victim = &valid ? rr : first;
  // Pointer only moves when it actually chose the victim; wraps since ENTRIES is a power of two.
  always_ff @(posedge clk)
    if (rst) rr <= '0;
    else if (fill && &valid) rr <= rr + 1'b1;
endmodule

// File: rtl/micro_tlb.sv
// micro_tlb: fully associative micro TLB with unmapped-segment bypass and main-TLB refill handshake
module micro_tlb
  import micro_tlb_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter bit IS_DATA = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] virt_addr,
  input  logic        req_valid,
  input  logic        is_store,
  input  logic [7:0]  cur_asid,
  input  logic        flush,
  input  logic [2:0]  cfg_k0,
  output logic [31:0] phys_addr,
  output logic        cached,
  output logic        xlat_ok,
  output logic        stall,
  output logic [1:0]  except_type,
  output logic        tlb_req,
  output logic [18:0] tlb_vpn2,
  input  logic        tlb_ack,
  input  logic        tlb_found,
  input  TLB_Entry    tlb_entry
);
  localparam int IW = $clog2(ENTRIES);
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_WAIT = 1'b1;
  utlb_entry_t ent [ENTRIES];
  logic state, mapped, hit, odd, fill, found, d, v;
  logic [ENTRIES-1:0] match, valid;
  logic [19:0] pfn;
  logic [2:0] c;
  logic [IW-1:0] victim;
  exc_e exc;
  assign odd = virt_addr[12];
  always_comb begin
    match = '0;
    valid = '0;
    found = 1'b0;
    pfn = '0;
    c = '0;
    d = 1'b0;
    v = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      valid[i] = ent[i].valid;
      match[i] = ent[i].valid && ent[i].vpn2 == virt_addr[31:13] && (ent[i].e.g || ent[i].e.asid == cur_asid);
      if (match[i]) begin
        found = ent[i].found;
        pfn = odd ? ent[i].e.pfn1 : ent[i].e.pfn0;
        c = odd ? ent[i].e.c1 : ent[i].e.c0;
        d = odd ? ent[i].e.d1 : ent[i].e.d0;
        v = odd ? ent[i].e.v1 : ent[i].e.v0;
      end
    end
  end
  assign mapped = virt_addr[31:30] != 2'b10;
  assign hit = |match;
  assign exc = !found ? EXC_REFILL : !v ? EXC_INVALID : (IS_DATA && is_store && !d) ? EXC_MODIFIED : EXC_NONE;
  assign stall = req_valid && mapped && !hit;
  assign phys_addr = !mapped ? virt_addr - (virt_addr[29] ? KSEG1_BASE : KSEG0_BASE) : {pfn, virt_addr[11:0]};
  assign cached = !mapped ? !virt_addr[29] && is_cached(cfg_k0) : is_cached(c);
  assign xlat_ok = req_valid && (!mapped || (hit && exc == EXC_NONE));
  assign except_type = (req_valid && mapped && hit) ? exc : EXC_NONE;
  assign tlb_req = state == ST_WAIT;
  // A flush in the ack cycle wins: the response is dropped rather than filled.
  assign fill = state == ST_WAIT && tlb_ack && !flush;
  micro_tlb_victim #(.ENTRIES(ENTRIES)) u_victim (
    .clk(clk), .rst(rst), .valid(valid), .fill(fill), .victim(victim)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      tlb_vpn2 <= '0;
      for (int i = 0; i < ENTRIES; i++) ent[i] <= '0;
    end else begin
      if (state == ST_IDLE && stall && !flush) begin
        state <= ST_WAIT;
        tlb_vpn2 <= virt_addr[31:13];
      end else if (state == ST_WAIT && (tlb_ack || flush)) begin
        state <= ST_IDLE;
      end
      for (int i = 0; i < ENTRIES; i++)
        if (flush) ent[i].valid <= 1'b0;
        else if (fill && victim == IW'(i))
          ent[i] <= '{valid: 1'b1, found: tlb_found, vpn2: tlb_vpn2, e: tlb_entry};
    end
  end
endmodule

// File: tb/tb_micro_tlb.sv
// tb_micro_tlb: randomized scoreboard bench for micro_tlb against a behavioural model
module tb_micro_tlb;
  import micro_tlb_pkg::*;
  localparam int N = 4;
  logic clk = 0, rst = 1, req_valid = 0, is_store = 0, flush = 0, tlb_ack = 0, tlb_found = 0;
  logic [31:0] virt_addr = 0, phys_addr;
  logic [7:0] cur_asid = 0;
  logic [2:0] cfg_k0 = 0;
  logic cached, xlat_ok, stall, tlb_req;
  logic [1:0] except_type;
  logic [18:0] tlb_vpn2;
  TLB_Entry tlb_entry = '0;
  micro_tlb #(.ENTRIES(N), .IS_DATA(1)) dut (
    .clk(clk), .rst(rst), .virt_addr(virt_addr), .req_valid(req_valid), .is_store(is_store),
    .cur_asid(cur_asid), .flush(flush), .cfg_k0(cfg_k0), .phys_addr(phys_addr), .cached(cached),
    .xlat_ok(xlat_ok), .stall(stall), .except_type(except_type), .tlb_req(tlb_req),
    .tlb_vpn2(tlb_vpn2), .tlb_ack(tlb_ack), .tlb_found(tlb_found), .tlb_entry(tlb_entry)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [31:0] pa;
    logic pchk, cached, xok, stall;
    logic [1:0] exc;
    logic req;
    logic [18:0] vpn;
  } exp_t;
  exp_t q[$];
  exp_t me;
  int checks = 0, errors = 0;
  logic [31:0] va_s = 0;
  logic rv_s = 0, st_s = 0, fl_s = 0, ak_s = 0, fd_s = 0, rs_s = 1, live = 0;
  logic [7:0] as_s = 0;
  logic [2:0] k0_s = 0;
  TLB_Entry en_s = '0;
  bit m_valid [N];
  bit m_found [N];
  bit [18:0] m_vpn [N];
  TLB_Entry m_e [N];
  int m_ptr = 0;
  bit m_wait = 0;
  bit [18:0] m_lvpn = 0;
  bit [18:0] pool [8];
  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // One cycle: drive inputs, predict outputs from the model, then advance the model across the edge.
  task automatic cyc();
    exp_t e;
    int h, vi;
    bit unm;
    bit [18:0] vp;
    bit [19:0] pfn;
    bit [2:0] c;
    bit d, v;
    @(posedge clk);
    #1;
    rst = rs_s; virt_addr = va_s; req_valid = rv_s; is_store = st_s; cur_asid = as_s;
    flush = fl_s; cfg_k0 = k0_s; tlb_ack = ak_s; tlb_found = fd_s; tlb_entry = en_s;
    vp = va_s[31:13];
    unm = va_s >= 32'h8000_0000 && va_s < 32'hC000_0000;
    h = -1;
    for (int i = 0; i < N; i++)
      if (m_valid[i] && m_vpn[i] == vp && (m_e[i].g || m_e[i].asid == as_s)) h = i;
    e = '0;
    e.stall = rv_s && !unm && h < 0;
    if (rv_s && !unm && h >= 0) begin
      pfn = va_s[12] ? m_e[h].pfn1 : m_e[h].pfn0;
      c = va_s[12] ? m_e[h].c1 : m_e[h].c0;
      d = va_s[12] ? m_e[h].d1 : m_e[h].d0;
      v = va_s[12] ? m_e[h].v1 : m_e[h].v0;
      e.exc = !m_found[h] ? 2'd1 : !v ? 2'd2 : (st_s && !d) ? 2'd3 : 2'd0;
      e.pa = {pfn, va_s[11:0]};
      e.cached = c == 3;
      e.pchk = 1;
    end
    if (rv_s && unm) begin
      e.pa = va_s - (va_s >= 32'hA000_0000 ? 32'hA000_0000 : 32'h8000_0000);
      e.cached = va_s < 32'hA000_0000 && k0_s == 3;
      e.pchk = 1;
    end
    e.xok = rv_s && (unm || (h >= 0 && e.exc == 0));
    e.req = m_wait;
    e.vpn = m_lvpn;
    if (live) q.push_back(e);
    if (rs_s) begin
      m_valid = '{default: 0};
      m_ptr = 0; m_wait = 0; m_lvpn = 0;
    end else if (fl_s) begin
      m_valid = '{default: 0};
      m_wait = 0;
    end else if (m_wait && ak_s) begin
      vi = -1;
      for (int i = 0; i < N; i++) if (!m_valid[i] && vi < 0) vi = i;
      if (vi < 0) begin
        vi = m_ptr;
        m_ptr = (m_ptr + 1) % N;
      end
      m_valid[vi] = 1; m_found[vi] = fd_s; m_vpn[vi] = m_lvpn; m_e[vi] = en_s;
      m_wait = 0;
    end else if (!m_wait && e.stall) begin
      m_wait = 1;
      m_lvpn = vp;
    end
  endtask
  task automatic go(logic [31:0] va, logic rv, logic st, logic ak, logic fd, logic fl);
    va_s = va; rv_s = rv; st_s = st; ak_s = ak; fd_s = fd; fl_s = fl;
    cyc();
  endtask
  task automatic fill_page(logic [31:0] va, logic fd);
    go(va, 1, 0, 0, 0, 0);
    go(va, 1, 0, 1, fd, 0);
  endtask
  initial forever begin
    @(negedge clk);
    if (q.size() != 0) begin
      me = q.pop_front();
      check("stall", stall, me.stall);
      check("xlat_ok", xlat_ok, me.xok);
      check("except_type", except_type, me.exc);
      check("tlb_req", tlb_req, me.req);
      if (me.req) check("tlb_vpn2", tlb_vpn2, me.vpn);
      if (me.pchk) begin
        check("phys_addr", phys_addr, me.pa);
        check("cached", cached, me.cached);
      end
    end
  end
  initial begin
    as_s = 5; k0_s = 3;
    go(0, 0, 0, 0, 0, 0);
    go(0, 0, 0, 0, 0, 0);
    rs_s = 0; live = 1;
    go(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("rst_tlb_req", tlb_req, 0);
    check("rst_tlb_vpn2", tlb_vpn2, 0);
    check("rst_xlat_ok", xlat_ok, 0);
    go(32'h9FC0_0010, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("kseg0_pa", phys_addr, 32'h1FC0_0010);
    check("kseg0_cached", cached, 1);
    check("kseg0_stall", stall, 0);
    check("kseg0_req", tlb_req, 0);
    go(32'hBFC0_0010, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("kseg1_pa", phys_addr, 32'h1FC0_0010);
    check("kseg1_cached", cached, 0);
    en_s = '0; en_s.asid = 5; en_s.pfn1 = 20'h12345; en_s.c1 = 3; en_s.v1 = 1;
    go(32'h0040_1004, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("cold_stall0", stall, 1);
    go(32'h0040_1004, 1, 0, 1, 1, 0);
    @(negedge clk);
    check("cold_stall1", stall, 1);
    check("cold_req", tlb_req, 1);
    check("cold_vpn2", tlb_vpn2, 19'h200);
    go(32'h0040_1004, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("hit_pa", phys_addr, 32'h1234_5004);
    check("hit_cached", cached, 1);
    check("hit_ok", xlat_ok, 1);
    check("hit_stall", stall, 0);
    fill_page(32'h0060_0000, 0);
    go(32'h0060_0000, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("refill_exc", except_type, 1);
    check("refill_ok", xlat_ok, 0);
    go(32'h0060_0000, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("refill_noreq", tlb_req, 0);
    en_s = '0; en_s.asid = 5; en_s.pfn0 = 20'hABCDE; en_s.v1 = 1;
    fill_page(32'h0080_0000, 1);
    go(32'h0080_0000, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("invalid_exc", except_type, 2);
    en_s = '0; en_s.asid = 5; en_s.pfn0 = 20'h55555; en_s.c0 = 2; en_s.v0 = 1;
    fill_page(32'h00A0_0000, 1);
    go(32'h00A0_0000, 1, 1, 0, 0, 0);
    @(negedge clk);
    check("mod_exc", except_type, 3);
    check("mod_ok", xlat_ok, 0);
    go(32'h00A0_0000, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("load_exc", except_type, 0);
    check("load_ok", xlat_ok, 1);
    fill_page(32'h00C0_0000, 1);
    go(32'h0040_1004, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("evict_miss", stall, 1);
    go(32'h0040_1004, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("evict_req", tlb_req, 1);
    go(32'h0040_1004, 1, 0, 1, 1, 1);
    go(32'h00A0_0000, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("flush_idle", tlb_req, 0);
    check("flush_miss", stall, 1);
    foreach (pool[i]) begin
      pool[i] = 19'($urandom);
      if (pool[i][18:17] == 2'b10) pool[i][18] = 0;
    end
    for (int n = 0; n < 3000; n++) begin
      rs_s = $urandom_range(199) == 0;
      fl_s = $urandom_range(39) == 0;
      rv_s = $urandom_range(7) != 0;
      st_s = $urandom_range(1);
      ak_s = $urandom_range(2) == 0;
      fd_s = $urandom_range(4) != 0;
      if ($urandom_range(19) == 0) k0_s = 3'($urandom_range(3, 2));
      if (!m_wait && $urandom_range(49) == 0) as_s = 8'($urandom_range(2, 1));
      va_s = $urandom_range(5) == 0 ? 32'h8000_0000 | ($urandom & 32'h3FFF_FFFF)
                                    : {pool[$urandom_range(7)], 13'($urandom)};
      en_s = TLB_Entry'({$urandom, $urandom, $urandom});
      en_s.asid = as_s;
      en_s.g = m_lvpn[0];
      cyc();
    end
    rs_s = 0;
    go(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    check("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/micro_tlb.md
MICRO_TLB -- requirements
Module: micro_tlb

Interface
REQ-001 SHALL have parameter ENTRIES, default 4, giving the number of fully associative buffer entries (power of two, 2..16).
REQ-002 SHALL have parameter IS_DATA, default 0; 1 enables store/dirty checking for the data side.
REQ-003 SHALL have port clk  in  1  clock.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports virt_addr in 32 lookup address; req_valid in 1 lookup request; is_store in 1 store access (ignored when IS_DATA=0).
REQ-006 SHALL have ports cur_asid in 8 current EntryHi ASID; flush in 1 invalidate all entries; cfg_k0 in 3 Config.K0.
REQ-007 SHALL have ports phys_addr out 32; cached out 1; xlat_ok out 1 translation usable; stall out 1; except_type out 2.
REQ-008 SHALL have ports tlb_req out 1; tlb_vpn2 out 19; tlb_ack in 1; tlb_found in 1; tlb_entry in TLB_Entry (main-TLB lookup handshake).

Function
REQ-009 Unmapped: 0x8000_0000..0x9FFF_FFFF SHALL give phys = va - 0x8000_0000, cached = (cfg_k0==3); 0xA000_0000..0xBFFF_FFFF SHALL give phys = va - 0xA000_0000, cached=0; both give xlat_ok=1, stall=0, except_type=NONE.
REQ-010 Mapped hit SHALL be entry i with valid, vpn2==va[31:13] and (G or asid==cur_asid); at most one entry matches.
REQ-011 On hit, va[12] SHALL select the even/odd half: phys={PFNx,va[11:0]}, cached=(Cx==3).
REQ-012 stall SHALL equal req_valid & mapped & ~hit, combinationally.
REQ-013 Exceptions on hit, priority order: found=0 -> REFILL; Vx=0 -> INVALID; IS_DATA & is_store & Dx=0 -> MODIFIED; else NONE; xlat_ok=1 only for NONE.
REQ-014 On miss, or req_valid=0: xlat_ok=0, except_type=NONE.
REQ-015 FSM states IDLE, WAIT. IDLE->WAIT on registered miss (stall=1 at a clock edge, flush=0); WAIT->IDLE on tlb_ack or flush.
REQ-016 In WAIT, tlb_req SHALL be 1 and tlb_vpn2 SHALL hold the VPN2 latched at entry to WAIT; tlb_req SHALL be 0 in IDLE.
REQ-017 tlb_ack may assert in the first WAIT cycle or later; the entry SHALL be written at that clock edge with latched VPN2, tlb_entry.ASID/G/PFN/C/D/V, found=tlb_found, valid=1.
REQ-018 A tlb_found=0 response SHALL still be filled (negative entry) so the retried lookup reports REFILL without a second main-TLB access.
REQ-019 Minimum miss-to-hit latency SHALL be 2 cycles (miss at t, ack in t+1, hit at t+2).
REQ-020 Victim SHALL be the lowest-index invalid entry; if all are valid, the entry at the round-robin pointer, which then increments modulo ENTRIES.
REQ-021 flush SHALL clear all valid bits at the next edge, forcing WAIT->IDLE; a tlb_ack in the same cycle SHALL be discarded (no fill).
REQ-022 If virt_addr changes while in WAIT, the fill SHALL still use the latched VPN2; the new address is looked up afterwards.
REQ-023 A changed cur_asid SHALL require no flush; non-global entries SHALL simply stop matching.

Reset
REQ-024 On rst: all valid=0, round-robin pointer=0, state=IDLE, tlb_req=0, tlb_vpn2=0; combinational outputs follow from the cleared buffer.
REQ-025 rst during WAIT SHALL abandon the request; a concurrent tlb_ack SHALL be ignored.

Structure
REQ-026 TLB_Entry, the buffer-entry struct, except_type encodings (NONE=0, REFILL=1, INVALID=2, MODIFIED=3) and segment base constants SHALL live in the shared CPU package.
REQ-027 A sub-module micro_tlb_victim (invalid-first priority encoder plus round-robin pointer) SHALL be used.

Verification
REQ-028 va=0x9FC0_0010, cfg_k0=3 -> phys=0x1FC0_0010, cached=1, stall=0, no tlb_req.
REQ-029 va=0x0040_1004 cold, ack next cycle with PFN1=0x12345, C1=3, V1=1 -> stall 2 cycles, then phys=0x1234_5004, cached=1, xlat_ok=1.
REQ-030 ENTRIES=4: fill 5 distinct VPN2s -> 5th replaces entry 0; re-accessing the first VPN2 misses and issues tlb_req.
REQ-031 tlb_found=0 response -> except_type=REFILL, xlat_ok=0, no further tlb_req for that VPN2; V0=0 hit -> INVALID.
REQ-032 IS_DATA=1, store to page with D=0 -> MODIFIED; load to the same page -> NONE.
REQ-033 flush asserted with tlb_ack in the same cycle -> state IDLE, all entries invalid, no fill, next lookup misses.
